gb_pulse_channel_gen: RTL
=========================

// Module: gb_pulse_channel_gen
// PURPOSE
//  Parametrised pulse-channel generator for the APU, covering channels 1/2 and future widened variants.
//  Integrates period divider, duty stepper, volume envelope, length counter and frequency sweep.
//  Outputs a VOL_W-bit level to the mixer and an enable flag to the NR52-style status logic.
// PARAMETERS
//  PERIOD_W  11  period/frequency register width; divider reloads from shadow when it reaches 2^PERIOD_W-1
//  LEN_W     6   length counter width; a note lasts 2^LEN_W-length length ticks
//  VOL_W     4   volume/level width
//  PRESCALE  4   clk cycles per divider increment (>=1)
//  STEPS     8   duty-waveform steps per period (power of 2, >=8)
// PORTS
//  clk                  in   1         system clock (T-cycle)
//  reset                in   1         asynchronous, active-low reset (0 = reset)
//  clk_length_ctr       in   1         length tick, 1-cycle strobe synchronous to clk
//  clk_vol_env          in   1         envelope tick, 1-cycle strobe
//  clk_sweep            in   1         sweep tick, 1-cycle strobe
//  start                in   1         trigger; acts on its rising edge (edge-detected internally)
//  frequency            in   PERIOD_W  period value
//  wave_duty            in   2         00=12.5% 01=25% 10=50% 11=75%
//  length               in   LEN_W     length load value
//  length_enable        in   1         1 = length counter may disable channel
//  initial_volume       in   VOL_W     volume loaded on trigger
//  envelope_increasing  in   1         envelope direction
//  envelope_pace        in   3         ticks per envelope step; 0 = envelope frozen
//  sweep_pace           in   3         ticks per sweep step; 0 = sweep frozen
//  sweep_decreasing     in   1         sweep direction
//  sweep_shifts         in   3         sweep shift amount
//  level                out  VOL_W     channel output
//  enable               out  1         channel active
// BEHAVIOUR
//  Reset (reset=0, async): step, divider, volume, length counter and shadow are 0; enabled=0; level=0; enable=0.
//  Trigger (cycle after start rises) loads: step=0; divider=frequency; prescaler=PRESCALE-1; shadow=frequency;
//    volume=initial_volume; env/sweep timers=pace; length ctr=length; enabled=1.
//    DAC-off (initial_volume==0 && !envelope_increasing) forces enabled=0.
//    If sweep_shifts!=0, overflow check runs on the trigger cycle.
//  Trigger has priority over every tick in the same cycle; ticks in that cycle are dropped.
//  Divider: prescaler counts down each clk; at 0 it reloads PRESCALE-1 and the divider acts:
//    divider==2^PERIOD_W-1 -> divider=shadow, step=step+1 (wraps STEPS-1 -> 0); else divider+1.
//  Duty: out bit=1 when step >= STEPS-STEPS*k/8, k=1,2,4,6 for duty 00..11.
//  level = (enabled && out bit) ? volume : 0. This is combinational from registered state, so 0 latency.
//  Envelope tick with pace!=0: timer-1; on reaching 0, reload pace and volume+-1, saturating at 0 / 2^VOL_W-1.
//  Length tick with length_enable && enabled: counter==2^LEN_W-1 -> enabled=0; else counter+1.
//  Sweep tick with pace!=0: timer-1; on reaching 0, reload pace.
//    new = shadow +- (shadow>>shifts), computed in PERIOD_W+1 bits.
//    Increasing and new>2^PERIOD_W-1 -> enabled=0 (overflow); else if shifts!=0, shadow=new.
//    Decreasing never overflows.
//  frequency register writes without a trigger do not touch shadow; the divider picks them up only on the next trigger.
//  Once disabled, the channel stays silent until the next trigger; divider and step keep running.
//  Reset mid-note: immediate silence; the next trigger after release starts cleanly.
// CONFIGURATION
//  GB_PULSE_CUSTOM_DUTY_EN defined:
//    adds ports duty_custom (in, 1) and duty_pattern (in, STEPS).
//    When duty_custom=1, out bit = duty_pattern[step]; wave_duty is ignored.
//  Not defined: those ports are absent and only the fixed duty table is used.
// TESTING
//  Reset: trigger vol=15 duty 10, pull reset=0 mid-note -> level=0, enable=0 in the same cycle (no clk edge needed).
//  Period: PRESCALE=4, frequency=2046, duty 10, vol=9 -> step advances every 8 clk, 64-clk wave;
//    level=9 during steps 4-7, else 0.
//  Length: length=62, length_enable=1 -> enable=1 after 1st length tick, 0 after 2nd; level=0 thereafter.
//  Envelope: vol=2, decreasing, pace=1 -> level amplitude 1 then 0 on successive ticks, stays 0.
//    vol=0 decreasing -> enable=0 right after trigger.
//  Sweep: frequency=1500, shifts=1, increasing -> 2250>2047, enable=0 right after trigger.
//    frequency=1000, shifts=1, pace=1 -> shadow 1500 after 1st tick, overflow disable on 2nd.
//  Macro on: duty_custom=1, duty_pattern=8'b1010_0101, vol=5 -> level 5,0,5,0,0,5,0,5 for steps 0..7.

Source files
------------

// File: rtl/gb_pulse_channel_gen.sv
// Pulse channel generator for the APU. It contains the prescaled period divider, duty stepper, volume envelope,
// length counter and frequency sweep. Optional macro GB_PULSE_CUSTOM_DUTY_EN adds a programmable duty pattern.
module gb_pulse_channel_gen #(
    parameter int PERIOD_W = 11,
    parameter int LEN_W    = 6,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 4,
    parameter int STEPS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_length_ctr,
    input  logic                clk_vol_env,
    input  logic                clk_sweep,
    input  logic                start,
    input  logic [PERIOD_W-1:0] frequency,
    input  logic [1:0]          wave_duty,
    input  logic [LEN_W-1:0]    length,
    input  logic                length_enable,
    input  logic [VOL_W-1:0]    initial_volume,
    input  logic                envelope_increasing,
    input  logic [2:0]          envelope_pace,
    input  logic [2:0]          sweep_pace,
    input  logic                sweep_decreasing,
    input  logic [2:0]          sweep_shifts,
`ifdef GB_PULSE_CUSTOM_DUTY_EN
    input  logic                duty_custom,
    input  logic [STEPS-1:0]    duty_pattern,
`endif
    output logic [VOL_W-1:0]    level,
    output logic                enable
);

    localparam int STEP_W = $clog2(STEPS);
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0] TH_12 = STEP_W'(STEPS - STEPS * 1 / 8);
    localparam logic [STEP_W-1:0] TH_25 = STEP_W'(STEPS - STEPS * 2 / 8);
    localparam logic [STEP_W-1:0] TH_50 = STEP_W'(STEPS - STEPS * 4 / 8);
    localparam logic [STEP_W-1:0] TH_75 = STEP_W'(STEPS - STEPS * 6 / 8);

    logic                r_start_d;
    logic [STEP_W-1:0]   r_step;
    logic [PERIOD_W-1:0] r_div;
    logic [PRE_W-1:0]    r_pre;
    logic [PERIOD_W-1:0] r_shadow;
    logic [VOL_W-1:0]    r_volume;
    logic [2:0]          r_env_timer;
    logic [2:0]          r_sweep_timer;
    logic [LEN_W-1:0]    r_len;
    logic                r_enabled;

    logic                w_trigger;
    logic                w_dac_off;
    logic                w_len_tick;
    logic                w_env_tick;
    logic                w_sweep_tick;
    logic                w_sweep_kill;
    logic [PERIOD_W-1:0] w_sweep_base;
    logic [PERIOD_W-1:0] w_sweep_delta;
    logic [PERIOD_W:0]   w_sweep_new;
    logic                w_sweep_ovf;
    logic [STEP_W-1:0]   w_duty_th;
    logic                w_out_bit;

    assign w_trigger    = start & ~r_start_d;
    assign w_dac_off    = (initial_volume == '0) && !envelope_increasing;
    assign w_len_tick   = clk_length_ctr && length_enable && r_enabled;
    assign w_env_tick   = clk_vol_env && (envelope_pace != 3'd0);
    assign w_sweep_tick = clk_sweep && (sweep_pace != 3'd0);

    // The trigger-time overflow check and the periodic sweep share one adder; only the operand differs.
    assign w_sweep_base  = w_trigger ? frequency : r_shadow;
    assign w_sweep_delta = w_sweep_base >> sweep_shifts;
    assign w_sweep_new   = sweep_decreasing ? ({1'b0, w_sweep_base} - {1'b0, w_sweep_delta})
                                            : ({1'b0, w_sweep_base} + {1'b0, w_sweep_delta});
    assign w_sweep_ovf   = !sweep_decreasing && w_sweep_new[PERIOD_W];
    assign w_sweep_kill  = w_sweep_tick && (r_sweep_timer <= 3'd1) && w_sweep_ovf;

    // NOTE: always_comb assigns a default first so that no path through the block can infer a latch.
    always_comb begin
        w_duty_th = TH_50;
        case (wave_duty)
            2'b00:   w_duty_th = TH_12;
            2'b01:   w_duty_th = TH_25;
            2'b10:   w_duty_th = TH_50;
            default: w_duty_th = TH_75;
        endcase
    end

`ifdef GB_PULSE_CUSTOM_DUTY_EN
    assign w_out_bit = duty_custom ? duty_pattern[r_step] : (r_step >= w_duty_th);
`else
    assign w_out_bit = (r_step >= w_duty_th);
`endif

    assign level  = (r_enabled && w_out_bit) ? r_volume : '0;
    assign enable = r_enabled;

    // NOTE: state uses non-blocking assignments, and the asynchronous reset silences the output with no clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_start_d     <= 1'b0;
            r_step        <= '0;
            r_div         <= '0;
            r_pre         <= '0;
            r_shadow      <= '0;
            r_volume      <= '0;
            r_env_timer   <= '0;
            r_sweep_timer <= '0;
            r_len         <= '0;
            r_enabled     <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_trigger) begin
                r_step        <= '0;
                r_div         <= frequency;
                r_pre         <= PRE_RELOAD;
                r_shadow      <= frequency;
                r_volume      <= initial_volume;
                r_env_timer   <= envelope_pace;
                r_sweep_timer <= sweep_pace;
                r_len         <= length;
                r_enabled     <= !w_dac_off && !((sweep_shifts != 3'd0) && w_sweep_ovf);
            end else begin
                if (r_pre == '0) begin
                    r_pre <= PRE_RELOAD;
                    if (&r_div) begin
                        r_div  <= r_shadow;
                        r_step <= r_step + 1'b1;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end else begin
                    r_pre <= r_pre - 1'b1;
                end

                if (w_env_tick) begin
                    if (r_env_timer <= 3'd1) begin
                        r_env_timer <= envelope_pace;
                        if (envelope_increasing && (r_volume != '1))
                            r_volume <= r_volume + 1'b1;
                        else if (!envelope_increasing && (r_volume != '0))
                            r_volume <= r_volume - 1'b1;
                    end else begin
                        r_env_timer <= r_env_timer - 1'b1;
                    end
                end

                if (w_len_tick && !(&r_len))
                    r_len <= r_len + 1'b1;

                if (w_sweep_tick) begin
                    if (r_sweep_timer <= 3'd1) begin
                        r_sweep_timer <= sweep_pace;
                        if (!w_sweep_ovf && (sweep_shifts != 3'd0))
                            r_shadow <= w_sweep_new[PERIOD_W-1:0];
                    end else begin
                        r_sweep_timer <= r_sweep_timer - 1'b1;
                    end
                end

                if ((w_len_tick && (&r_len)) || w_sweep_kill)
                    r_enabled <= 1'b0;
            end
        end
    end

endmodule
